grid_io_cfg_array: RTL and testbench
====================================

Name: grid_io_cfg_array

Overview:
- Parametrised successor to the fixed 8-subtile IO grid tile: NUM_IO IO subtiles, each with a 3-bit configuration (output enable, input enable, output invert).
- Configuration is loaded through one serial configuration chain (ccff_head to ccff_tail), then held in a shadow register.
- The shadow register is applied only when a load completes with an exact bit count.
- Pads are forced to a safe state during reconfiguration.
- Sits at the fabric perimeter between routing-side outpad/inpad pins and split pad signals (in/out/oe).

Parameters:
- NUM_IO, 8, number of IO subtiles (≥1).
- CHAIN_LEN (localparam), 3*NUM_IO, total configuration bits.
- CNT_W (localparam), $clog2(CHAIN_LEN+2), bit-counter width.

Ports:
- prog_clk  input  1  configuration clock; the only clock.
- prog_reset  input  1  asynchronous, active-low reset.
- cfg_done  input  1  1 = configuration complete, fabric active; 0 = shifting.
- ccff_head  input  1  serial configuration data in.
- ccff_tail  output  1  serial configuration data out (last chain bit).
- io_outpad  input  NUM_IO  fabric-side output data, one bit per subtile.
- io_inpad  output  NUM_IO  fabric-side input data, one bit per subtile.
- gpio_pad_in  input  NUM_IO  pad receiver data.
- gpio_pad_out  output  NUM_IO  pad driver data.
- gpio_pad_oe  output  NUM_IO  pad driver enable, active-high.
- cfg_valid  output  1  shadow register holds an applied configuration.
- cfg_error  output  1  sticky flag: last load had the wrong bit count.

Behaviour:
- Reset (prog_reset=0, asynchronous) clears:
  - chain[CHAIN_LEN-1:0], shadow[CHAIN_LEN-1:0], count, cfg_done_q, cfg_valid, cfg_error.
  - Result: ccff_tail=0, gpio_pad_oe=0, io_inpad=0, gpio_pad_out=io_outpad.
  - Reset mid-load discards all state; pads are disabled immediately.
- Subtile k's bits are shadow[3k] OE, shadow[3k+1] IE, shadow[3k+2] INV.
- Shift: on each prog_clk rise with cfg_done=0:
  - chain <= {chain[CHAIN_LEN-2:0], ccff_head}.
  - The first bit shifted lands in chain[CHAIN_LEN-1], which is subtile NUM_IO-1 INV.
- With cfg_done=1 the chain holds. ccff_tail = chain[CHAIN_LEN-1], so the head-to-tail latency is CHAIN_LEN shift cycles.
- cfg_done_q <= cfg_done every cycle. rise = cfg_done & ~cfg_done_q.
- count behaviour:
  - cfg_done=0: count increments once per shift, saturating at CHAIN_LEN+1.
  - cfg_done=1: count <= 0.
  - The rise cycle evaluates the pre-clear count.
- On a rise cycle:
  - count==CHAIN_LEN: shadow <= chain; cfg_valid <= 1; cfg_error <= 0.
  - Otherwise (short or long load): shadow and cfg_valid unchanged; cfg_error <= 1.
- cfg_error is sticky until the next successful apply or reset.
- No shift occurs on the rise cycle (cfg_done=1).
- Datapath (combinational from registers and cfg_done), with active = cfg_done & cfg_valid:
  - gpio_pad_oe[k] = active & shadow[3k].
  - gpio_pad_out[k] = io_outpad[k] ^ shadow[3k+2].
  - io_inpad[k] = active & shadow[3k+1] & gpio_pad_in[k].
- OE=1 with IE=1 is legal: the subtile reads back its own pad.
- Reconfiguration while active:
  - Pads are disabled in the same cycle cfg_done falls; shadow is retained.
  - After a bad reload, the old shadow becomes active again when cfg_done returns to 1.
  - The new chain contents are ignored until a correct-length load.
- cfg_done pulsing 1 for a single cycle with count==0 counts as a load of 0 bits: error if CHAIN_LEN≠0.
- Implementation: all state in one always block on posedge prog_clk / negedge prog_reset; no latches; no inout ports.

Test Plan:
- NUM_IO=8 (CHAIN_LEN=24), reset asserted → all outputs 0 except gpio_pad_out=io_outpad; release with cfg_done=1, no load → io_inpad=0, gpio_pad_oe=0, cfg_valid=0.
- cfg_done=0, shift 24 bits so subtile 0 gets OE=1, IE=0, INV=1 and subtile 7 gets OE=0, IE=1, INV=0; raise cfg_done → next cycle cfg_valid=1, gpio_pad_oe=8'h01, gpio_pad_out[0]=~io_outpad[0], io_inpad[7] follows gpio_pad_in[7], io_inpad[6:0]=0.
- After a valid load, drop cfg_done, shift 23 bits, raise cfg_done → cfg_error=1, cfg_valid=1; outputs match the previous configuration again; oe=0 throughout the shift window.
- Shift 30 bits (overflow), raise cfg_done → cfg_error=1; then a correct 24-bit load → cfg_error=0 and the new config is applied.
- Chain pass-through: shift pattern 1,0,0,… with cfg_done=0 → ccff_tail goes high exactly 24 clocks after the 1 entered, then returns to 0.
- Assert prog_reset mid-shift (bit 10 of 24) asynchronously between edges → ccff_tail, gpio_pad_oe, io_inpad, cfg_valid and cfg_error go to 0 immediately; a subsequent full load succeeds.

Source files
------------

// File: rtl/grid_io_cfg_array.sv
// Perimeter IO tile: NUM_IO subtiles, each with OE/IE/INV bits loaded over one serial chain.
// A load takes effect only if it has exactly CHAIN_LEN bits. Pads are held safe while shifting.
module grid_io_cfg_array #(
  parameter int unsigned NUM_IO = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_done,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad,
  input  logic [NUM_IO-1:0] gpio_pad_in,
  output logic [NUM_IO-1:0] gpio_pad_out,
  output logic [NUM_IO-1:0] gpio_pad_oe,
  output logic              cfg_valid,
  output logic              cfg_error
);

  localparam int unsigned CHAIN_LEN = 3 * NUM_IO;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 cfg_done_q;
  logic                 cfg_valid_q, cfg_valid_d;
  logic                 cfg_error_q, cfg_error_d;
  logic                 rise;
  logic                 active;

  assign rise = cfg_done & ~cfg_done_q;

  always_comb begin
    chain_d     = chain_q;
    shadow_d    = shadow_q;
    count_d     = count_q;
    cfg_valid_d = cfg_valid_q;
    cfg_error_d = cfg_error_q;
    if (cfg_done) begin
      count_d = '0;
      // The rise cycle judges the bit count accumulated before this clear.
      if (rise) begin
        if (count_q == CntFull) begin
          shadow_d    = chain_q;
          cfg_valid_d = 1'b1;
          cfg_error_d = 1'b0;
        end else begin
          cfg_error_d = 1'b1;
        end
      end
    end else begin
      chain_d = {chain_q[CHAIN_LEN-2:0], ccff_head};
      if (count_q != CntMax) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      chain_q     <= '0;
      shadow_q    <= '0;
      count_q     <= '0;
      cfg_done_q  <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      chain_q     <= chain_d;
      shadow_q    <= shadow_d;
      count_q     <= count_d;
      cfg_done_q  <= cfg_done;
      cfg_valid_q <= cfg_valid_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign active    = cfg_done & cfg_valid_q;
  assign ccff_tail = chain_q[CHAIN_LEN-1];
  assign cfg_valid = cfg_valid_q;
  assign cfg_error = cfg_error_q;

  // Subtile k: shadow[3k] OE, shadow[3k+1] IE, shadow[3k+2] INV.
  always_comb begin
    gpio_pad_oe  = '0;
    gpio_pad_out = '0;
    io_inpad     = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      gpio_pad_oe[k]  = active & shadow_q[3*k];
      gpio_pad_out[k] = io_outpad[k] ^ shadow_q[3*k+2];
      io_inpad[k]     = active & shadow_q[3*k+1] & gpio_pad_in[k];
    end
  end

endmodule

// File: tb/tb_grid_io_cfg_array.sv
// Directed bench for grid_io_cfg_array with NUM_IO=8 (24-bit chain).
module tb_grid_io_cfg_array;

  logic       prog_clk;
  logic       prog_reset;
  logic       cfg_done;
  logic       ccff_head;
  logic       ccff_tail;
  logic [7:0] io_outpad;
  logic [7:0] io_inpad;
  logic [7:0] gpio_pad_in;
  logic [7:0] gpio_pad_out;
  logic [7:0] gpio_pad_oe;
  logic       cfg_valid;
  logic       cfg_error;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;

  grid_io_cfg_array #(.NUM_IO(8)) dut (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .cfg_done    (cfg_done),
    .ccff_head   (ccff_head),
    .ccff_tail   (ccff_tail),
    .io_outpad   (io_outpad),
    .io_inpad    (io_inpad),
    .gpio_pad_in (gpio_pad_in),
    .gpio_pad_out(gpio_pad_out),
    .gpio_pad_oe (gpio_pad_oe),
    .cfg_valid   (cfg_valid),
    .cfg_error   (cfg_error)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Shifts vec[n-1] first so that vec[i] ends up in chain bit i after a full load.
  task automatic shift_bits(input logic [31:0] vec, input int n);
    cfg_done = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      ccff_head = vec[i];
      tick();
    end
    ccff_head = 1'b0;
  endtask

  task automatic raise();
    cfg_done = 1'b1;
    tick();
  endtask

  initial begin
    prog_reset  = 1'b0;
    cfg_done    = 1'b1;
    ccff_head   = 1'b0;
    io_outpad   = 8'hA5;
    gpio_pad_in = 8'hFF;
    #12;
    check("rst_tail",  32'(ccff_tail),    32'h0);
    check("rst_oe",    32'(gpio_pad_oe),  32'h0);
    check("rst_inpad", 32'(io_inpad),     32'h0);
    check("rst_out",   32'(gpio_pad_out), 32'hA5);
    check("rst_valid", 32'(cfg_valid),    32'h0);
    check("rst_error", 32'(cfg_error),    32'h0);

    // Release with cfg_done high: the first edge is a zero-bit load.
    prog_reset = 1'b1;
    tick();
    check("noload_valid", 32'(cfg_valid),   32'h0);
    check("noload_oe",    32'(gpio_pad_oe), 32'h0);
    check("noload_inpad", 32'(io_inpad),    32'h0);
    check("noload_error", 32'(cfg_error),   32'h1);

    // Subtile 0: OE=1 IE=0 INV=1; subtile 7: OE=0 IE=1 INV=0.
    shift_bits(32'h0040_0005, 24);
    raise();
    check("ld1_valid", 32'(cfg_valid),    32'h1);
    check("ld1_error", 32'(cfg_error),    32'h0);
    check("ld1_oe",    32'(gpio_pad_oe),  32'h01);
    check("ld1_out",   32'(gpio_pad_out), 32'hA4);
    check("ld1_inpad", 32'(io_inpad),     32'h80);
    gpio_pad_in = 8'h7F;
    #1;
    check("ld1_inpad_lo", 32'(io_inpad), 32'h00);
    gpio_pad_in = 8'hFF;

    // Short reload: pads drop as soon as cfg_done falls, old config returns after.
    cfg_done = 1'b0;
    #1;
    check("short_oe_fall",    32'(gpio_pad_oe), 32'h0);
    check("short_inpad_fall", 32'(io_inpad),    32'h0);
    shift_bits(32'hFFFF_FFFF, 12);
    check("short_oe_mid", 32'(gpio_pad_oe), 32'h0);
    shift_bits(32'hFFFF_FFFF, 11);
    check("short_oe_end", 32'(gpio_pad_oe), 32'h0);
    raise();
    check("short_error", 32'(cfg_error),    32'h1);
    check("short_valid", 32'(cfg_valid),    32'h1);
    check("short_oe",    32'(gpio_pad_oe),  32'h01);
    check("short_out",   32'(gpio_pad_out), 32'hA4);
    check("short_inpad", 32'(io_inpad),     32'h80);

    // Overflow load of 30 bits.
    shift_bits(32'hFFFF_FFFF, 30);
    raise();
    check("long_error", 32'(cfg_error),   32'h1);
    check("long_oe",    32'(gpio_pad_oe), 32'h01);

    // Subtile 3: OE=1 IE=1; subtile 5: INV=1.
    shift_bits(32'h0002_0600, 24);
    raise();
    check("ld2_error", 32'(cfg_error),    32'h0);
    check("ld2_valid", 32'(cfg_valid),    32'h1);
    check("ld2_oe",    32'(gpio_pad_oe),  32'h08);
    check("ld2_out",   32'(gpio_pad_out), 32'h85);
    check("ld2_inpad", 32'(io_inpad),     32'h08);

    // Pass-through latency: a single 1 after a flushed chain.
    shift_bits(32'h0, 24);
    ccff_head = 1'b1;
    tick();
    ccff_head = 1'b0;
    edges = 0;
    while (ccff_tail == 1'b0 && edges < 40) begin
      tick();
      edges++;
    end
    check("pass_edges", 32'(edges + 1), 32'd24);
    tick();
    check("pass_tail_low", 32'(ccff_tail), 32'h0);

    // Mid-shift asynchronous reset with sticky error and all-ones chain.
    shift_bits(32'hFFFF_FFFF, 25);
    raise();
    check("pre_rst_error", 32'(cfg_error), 32'h1);
    shift_bits(32'hFFFF_FFFF, 10);
    check("pre_rst_tail", 32'(ccff_tail), 32'h1);
    #2;
    prog_reset = 1'b0;
    #1;
    check("arst_tail",  32'(ccff_tail),   32'h0);
    check("arst_oe",    32'(gpio_pad_oe), 32'h0);
    check("arst_inpad", 32'(io_inpad),    32'h0);
    check("arst_valid", 32'(cfg_valid),   32'h0);
    check("arst_error", 32'(cfg_error),   32'h0);
    #3;
    prog_reset = 1'b1;
    shift_bits(32'h0040_0005, 24);
    raise();
    check("post_valid", 32'(cfg_valid),    32'h1);
    check("post_error", 32'(cfg_error),    32'h0);
    check("post_oe",    32'(gpio_pad_oe),  32'h01);
    check("post_out",   32'(gpio_pad_out), 32'hA4);
    check("post_inpad", 32'(io_inpad),     32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
